// File: rtl/envelope_pkg.sv
// Shared types and constants for the exponential-decay envelope and its CORDIC interface.
package envelope_pkg;

    typedef enum logic [2:0] {IDLE, READY, ISSUE, WAIT, OUT} state_t;

    localparam logic [15:0] LN2_Q16     = 16'd45426;
    localparam int          FRAC_BITS   = 16;
    localparam int          PHASE_FRAC  = 13;
    localparam int          CORDIC_FRAC = 14;
    // Q0.16 fraction times Q0.16 ln2 lands in Q.32; shift down to the CORDIC's Q.13 phase
    localparam int          PHASE_SHIFT = 2 * FRAC_BITS - PHASE_FRAC;

    localparam int SINH_MSB = 31;
    localparam int SINH_LSB = 16;
    localparam int COSH_MSB = 15;
    localparam int COSH_LSB = 0;

    // e^x = cosh(x) + sinh(x), kept at 17b so the sum of two Q.14 fields cannot wrap
    function automatic logic signed [16:0] exp_sum(input logic [31:0] dout);
        logic signed [16:0] s;
        logic signed [16:0] c;
        s = $signed({dout[SINH_MSB], dout[SINH_MSB:SINH_LSB]});
        c = $signed({dout[COSH_MSB], dout[COSH_MSB:COSH_LSB]});
        return s + c;
    endfunction

endpackage

// File: rtl/envelope_phase_reduce.sv
// Maps the log2-domain fraction f to the CORDIC phase -f*ln2 in signed Q.13.
module envelope_phase_reduce
    import envelope_pkg::*;
(
    input  logic [15:0] frac,
    output logic [15:0] phase
);

    logic [31:0] prod;
    logic [15:0] mag;

    assign prod  = {16'b0, frac} * {16'b0, LN2_Q16};
    assign mag   = 16'(prod >> PHASE_SHIFT);
    assign phase = -mag;

endmodule

// File: rtl/exp_decay_envelope.sv
// Exponential-decay envelope: 2^-k range reduction around a sinh/cosh CORDIC, one sample per tick.
module exp_decay_envelope
    import envelope_pkg::*;
#(
    parameter int ACC_INT_BITS = 8,
    parameter int RATE_WIDTH   = 16,
    parameter int ENV_WIDTH    = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  trigger,
    input  logic [RATE_WIDTH-1:0] decay_rate,
    input  logic                  sample_tick,
    output logic                  m_axis_phase_tvalid,
    input  logic                  m_axis_phase_tready,
    output logic [15:0]           m_axis_phase_tdata,
    input  logic                  s_axis_dout_tvalid,
    input  logic [31:0]           s_axis_dout_tdata,
    output logic [ENV_WIDTH-1:0]  env_out,
    output logic                  env_valid,
    output logic                  active,
    output logic                  overrun
);

    localparam int ACC_W = ACC_INT_BITS + FRAC_BITS;

    state_t                    state, state_nxt;
    logic [ACC_W-1:0]          acc;
    logic [RATE_WIDTH-1:0]     rate;
    logic [ACC_INT_BITS-1:0]   k_lat;
    logic signed [16:0]        e_q;
    logic [15:0]               phase_q;
    logic [15:0]               phase_c;
    logic                      drop_q;

    logic [ACC_INT_BITS-1:0]   k;
    logic [15:0]               f;
    logic [ACC_W:0]            acc_sum;
    logic [ACC_W-1:0]          acc_sat;
    logic                      decay_done;
    logic                      hs;
    logic                      load_issue;
    logic                      finish;
    logic                      emit;
    logic                      busy;

    assign k          = acc[ACC_W-1:FRAC_BITS];
    assign f          = acc[FRAC_BITS-1:0];
    assign acc_sum    = {1'b0, acc} + {{(ACC_W + 1 - RATE_WIDTH){1'b0}}, rate};
    assign acc_sat    = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign decay_done = (int'(k) >= ENV_WIDTH);

    envelope_phase_reduce u_phase (
        .frac  (f),
        .phase (phase_c)
    );

    // Mantissa in (0.5, 1.0] as Q.14, clamped, rescaled to Q0.ENV_WIDTH, then the octave shift
    function automatic logic [ENV_WIDTH-1:0] scale_env(input logic signed [16:0] e,
                                                       input logic [ACC_INT_BITS-1:0] sh);
        logic [ENV_WIDTH-1:0] m;
        if (e <= 17'sd0)
            m = '0;
        else if (e >= 17'sd16384)
            m = '1;
        else
            m = ENV_WIDTH'(e[CORDIC_FRAC-1:0]) << (ENV_WIDTH - CORDIC_FRAC);
        return m >> sh;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (trigger) state_nxt = READY;
            READY: begin
                if (trigger)          state_nxt = READY;
                else if (sample_tick) state_nxt = decay_done ? IDLE : ISSUE;
            end
            // a restart during ISSUE still finishes the transfer, then abandons the result
            ISSUE: if (m_axis_phase_tready) state_nxt = (drop_q || trigger) ? READY : WAIT;
            WAIT: begin
                if (trigger)                 state_nxt = READY;
                else if (s_axis_dout_tvalid) state_nxt = OUT;
            end
            OUT:     state_nxt = READY;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axis_phase_tvalid = (state == ISSUE);
        hs                  = m_axis_phase_tvalid && m_axis_phase_tready;
        load_issue          = (state == READY) && sample_tick && !trigger && !decay_done;
        finish              = (state == READY) && sample_tick && !trigger && decay_done;
        emit                = (state == OUT) && !trigger;
        busy                = (state == ISSUE) || (state == WAIT) || (state == OUT);
    end

    assign m_axis_phase_tdata = phase_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc       <= '0;
            rate      <= '0;
            k_lat     <= '0;
            e_q       <= '0;
            phase_q   <= '0;
            drop_q    <= 1'b0;
            env_out   <= '0;
            env_valid <= 1'b0;
            active    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            env_valid <= 1'b0;
            if (hs) drop_q <= 1'b0;
            if (trigger) begin
                acc     <= '0;
                rate    <= decay_rate;
                active  <= 1'b1;
                overrun <= 1'b0;
                if ((state == ISSUE) && !hs) drop_q <= 1'b1;
            end else begin
                if (sample_tick && busy) overrun <= 1'b1;
                if (load_issue) begin
                    phase_q <= phase_c;
                    k_lat   <= k;
                    acc     <= acc_sat;
                end
                if (finish) begin
                    env_out   <= '0;
                    env_valid <= 1'b1;
                    active    <= 1'b0;
                end
                if ((state == WAIT) && s_axis_dout_tvalid) e_q <= exp_sum(s_axis_dout_tdata);
                if (emit) begin
                    env_out   <= scale_env(e_q, k_lat);
                    env_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exp_decay_envelope.sv
// Directed bench for exp_decay_envelope with a hand-driven CORDIC stand-in.
module tb_exp_decay_envelope;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] decay_rate = '0;
    logic        sample_tick = 1'b0;
    logic        m_axis_phase_tvalid;
    logic        m_axis_phase_tready = 1'b1;
    logic [15:0] m_axis_phase_tdata;
    logic        s_axis_dout_tvalid = 1'b0;
    logic [31:0] s_axis_dout_tdata = '0;
    logic [15:0] env_out;
    logic        env_valid;
    logic        active;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    exp_decay_envelope dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .trigger             (trigger),
        .decay_rate          (decay_rate),
        .sample_tick         (sample_tick),
        .m_axis_phase_tvalid (m_axis_phase_tvalid),
        .m_axis_phase_tready (m_axis_phase_tready),
        .m_axis_phase_tdata  (m_axis_phase_tdata),
        .s_axis_dout_tvalid  (s_axis_dout_tvalid),
        .s_axis_dout_tdata   (s_axis_dout_tdata),
        .env_out             (env_out),
        .env_valid           (env_valid),
        .active              (active),
        .overrun             (overrun)
    );

    always #5 aclk = ~aclk;

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_trigger(input logic [15:0] r);
        decay_rate = r;
        trigger    = 1'b1;
        cyc();
        trigger    = 1'b0;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic wait_tvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_phase_tvalid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic send_dout(input logic [31:0] d);
        s_axis_dout_tvalid = 1'b1;
        s_axis_dout_tdata  = d;
        cyc();
        s_axis_dout_tvalid = 1'b0;
    endtask

    task automatic wait_env(output bit got, output logic [15:0] v);
        got = 1'b0;
        v   = 'x;
        for (int i = 0; i < 10; i++) begin
            if (env_valid) begin
                got = 1'b1;
                v   = env_out;
                break;
            end
            cyc();
        end
    endtask

    task automatic run_sample(input logic [31:0] resp, output logic [15:0] ph,
                              output bit got, output logic [15:0] env);
        bit ok;
        pulse_tick();
        wait_tvalid(ok);
        ph = ok ? m_axis_phase_tdata : 16'hxxxx;
        cyc();
        send_dout(resp);
        wait_env(got, env);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #3;
        n_checks++;
        if ({env_out, env_valid, active, overrun, m_axis_phase_tvalid, m_axis_phase_tdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got env=%h vld=%b act=%b ovr=%b tv=%b td=%h, want all 0",
                     env_out, env_valid, active, overrun, m_axis_phase_tvalid, m_axis_phase_tdata);
        end
        cyc();
        aresetn = 1'b1;
        cyc();
        send_dout(32'h0000_4000);
        cyc();
        n_checks++;
        if (env_valid !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_dout_ignored: got vld=%b act=%b, want 0 0", env_valid, active);
        end
    endtask

    task automatic test_first_sample();
        logic [15:0] ph, env;
        bit got;
        pulse_trigger(16'h0100);
        n_checks++;
        if (active !== 1'b1) begin
            n_fail++;
            $display("FAIL trigger_active: got %b want 1", active);
        end
        run_sample(32'h0000_4000, ph, got, env);
        n_checks++;
        if (ph !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_phase: got %h want 0000", ph);
        end
        n_checks++;
        if (!got || env !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL first_env: got valid=%b env=%h want 1 FFFF", got, env);
        end
        cyc();
        n_checks++;
        if (env_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL env_valid_pulse: got %b want 0 one cycle later", env_valid);
        end
        // f = 0x0100 -> 22 -> -22; negative sum clamps to 0
        run_sample(32'hFFFF_0000, ph, got, env);
        n_checks++;
        if (ph !== 16'hFFEA) begin
            n_fail++;
            $display("FAIL small_phase: got %h want FFEA", ph);
        end
        n_checks++;
        if (!got || env !== 16'h0000) begin
            n_fail++;
            $display("FAIL neg_clamp: got valid=%b env=%h want 1 0000", got, env);
        end
    endtask

    task automatic test_octave_fraction();
        logic [15:0] ph, env;
        bit got;
        pulse_trigger(16'hC000);
        run_sample(32'h0000_4000, ph, got, env);
        run_sample(32'h0000_4000, ph, got, env);
        n_checks++;
        if (ph !== 16'hEF5E || !got || env !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL frac_c000: got ph=%h valid=%b env=%h want EF5E 1 FFFF", ph, got, env);
        end
        // acc = 0x018000: sinh=-5793, cosh=17378, sum 11585
        run_sample(32'hE95F_43E2, ph, got, env);
        n_checks++;
        if (ph !== 16'hF4E9) begin
            n_fail++;
            $display("FAIL k1_phase: got %h want F4E9", ph);
        end
        n_checks++;
        if (!got || env !== 16'h5A82) begin
            n_fail++;
            $display("FAIL k1_env: got valid=%b env=%h want 1 5A82", got, env);
        end
    endtask

    task automatic test_decay_end();
        logic [15:0] ph, env;
        bit got;
        bit quiet;
        pulse_trigger(16'hFFFF);
        for (int i = 0; i < 17; i++) run_sample(32'h0000_4000, ph, got, env);
        n_checks++;
        if (ph !== 16'hE9D4 || !got || env !== 16'h0001) begin
            n_fail++;
            $display("FAIL k15_sample: got ph=%h valid=%b env=%h want E9D4 1 0001", ph, got, env);
        end
        pulse_tick();
        n_checks++;
        if (env_valid !== 1'b1 || env_out !== 16'h0000 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL decay_end: got vld=%b env=%h act=%b want 1 0000 0", env_valid, env_out, active);
        end
        quiet = 1'b1;
        pulse_tick();
        for (int i = 0; i < 5; i++) begin
            if (m_axis_phase_tvalid !== 1'b0 || env_valid !== 1'b0) quiet = 1'b0;
            cyc();
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL idle_after_decay: got activity=1 want 0");
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ph, env;
        bit got;
        bit held;
        pulse_trigger(16'hC000);
        run_sample(32'h0000_4000, ph, got, env);
        m_axis_phase_tready = 1'b0;
        pulse_tick();
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (m_axis_phase_tvalid !== 1'b1 || m_axis_phase_tdata !== 16'hEF5E) held = 1'b0;
            cyc();
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL stall_hold: got tv=%b td=%h want 1 EF5E held", m_axis_phase_tvalid, m_axis_phase_tdata);
        end
        m_axis_phase_tready = 1'b1;
        cyc();
        n_checks++;
        if (m_axis_phase_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_transfer: got tv=%b want 0", m_axis_phase_tvalid);
        end
        send_dout(32'h0000_4000);
        wait_env(got, env);
        n_checks++;
        if (!got || env !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_env: got valid=%b env=%h want 1 FFFF", got, env);
        end
    endtask

    task automatic test_trigger_in_wait();
        logic [15:0] ph, env;
        bit got, ok;
        pulse_trigger(16'hC000);
        run_sample(32'h0000_4000, ph, got, env);
        pulse_tick();
        wait_tvalid(ok);
        cyc();
        pulse_trigger(16'h0100);
        send_dout(32'hE95F_43E2);
        wait_env(got, env);
        n_checks++;
        if (!ok || got) begin
            n_fail++;
            $display("FAIL late_result_dropped: got issue=%b env_valid=%b want 1 0", ok, got);
        end
        run_sample(32'h0000_4000, ph, got, env);
        n_checks++;
        if (ph !== 16'h0000 || !got || env !== 16'hFFFF || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_sample: got ph=%h valid=%b env=%h ovr=%b want 0000 1 FFFF 0",
                     ph, got, env, overrun);
        end
    endtask

    task automatic test_overrun_and_reset();
        logic [15:0] env;
        bit got, ok, quiet;
        pulse_trigger(16'h0100);
        pulse_tick();
        wait_tvalid(ok);
        cyc();
        pulse_tick();
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        send_dout(32'h0000_4000);
        wait_env(got, env);
        n_checks++;
        if (overrun !== 1'b1 || !got || env !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL overrun_sticky: got ovr=%b valid=%b env=%h want 1 1 FFFF", overrun, got, env);
        end
        pulse_trigger(16'h0100);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        decay_rate  = 16'h0100;
        trigger     = 1'b1;
        sample_tick = 1'b1;
        cyc();
        trigger     = 1'b0;
        sample_tick = 1'b0;
        n_checks++;
        if (m_axis_phase_tvalid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL trigger_beats_tick: got tv=%b ovr=%b want 0 0", m_axis_phase_tvalid, overrun);
        end
        pulse_tick();
        wait_tvalid(ok);
        cyc();
        pulse_tick();
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (!ok || {env_out, env_valid, active, overrun, m_axis_phase_tvalid, m_axis_phase_tdata} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got issue=%b env=%h vld=%b act=%b ovr=%b tv=%b want 1 and all 0",
                     ok, env_out, env_valid, active, overrun, m_axis_phase_tvalid);
        end
        #2;
        aresetn = 1'b1;
        cyc();
        send_dout(32'h0000_4000);
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (env_valid !== 1'b0 || active !== 1'b0) quiet = 1'b0;
            cyc();
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL post_reset_dout: got activity=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_octave_fraction();
        test_decay_end();
        test_backpressure();
        test_trigger_in_wait();
        test_overrun_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
